// File: rtl/registo_pkg.sv
// Shared definitions for the six-digit input register: FSM states and sizing constants.
// Optional BCD validation is selected with the BCD_CHECK_EN macro.
package registo_pkg;

  localparam int NUM_DIG = 6;
  localparam int BCD_MAX = 9;

  typedef enum logic [1:0] {
    VAZIO   = 2'd0,
    CARREGA = 2'd1,
    CHEIO   = 2'd2
  } estado_t;

endpackage

// File: rtl/valida_bcd.sv
// Combinational digit check: ok is high when dig_in is a legal BCD digit (0..BCD_MAX).
// Only compiled and instantiated when BCD_CHECK_EN is defined.
`ifdef BCD_CHECK_EN
module valida_bcd #(
  parameter int DIG_W = 4
) (
  input  logic [DIG_W-1:0] dig_in,
  output logic             ok
);
  import registo_pkg::*;

  // Widen both sides so narrow digit widths never truncate the limit.
  assign ok = (32'(dig_in) <= 32'(BCD_MAX));

endmodule
`endif

// File: rtl/registo_digitos.sv
// Collects six digits in fixed order m0..m5 and holds them until downstream consumes the set.
// Macro BCD_CHECK_EN enables rejection of non-BCD digits with a one-cycle erro pulse.
module registo_digitos #(
  parameter int DIG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIG_W-1:0] dig_in,
  input  logic             dig_valid,
  output logic             dig_ready,
  input  logic             limpar,
  input  logic             consumir,
  output logic [DIG_W-1:0] m0,
  output logic [DIG_W-1:0] m1,
  output logic [DIG_W-1:0] m2,
  output logic [DIG_W-1:0] m3,
  output logic [DIG_W-1:0] m4,
  output logic [DIG_W-1:0] m5,
  output logic             pronto,
  output logic [2:0]       contagem,
  output logic             erro
);
  import registo_pkg::*;

  estado_t          state;
  logic [2:0]       cnt;
  logic [DIG_W-1:0] m [NUM_DIG];
  logic             pronto_q;
  logic             digit_ok;
  logic             accept;
  logic             last;

  assign dig_ready = (state != CHEIO);
  assign accept    = dig_valid && dig_ready && digit_ok;
  assign last      = (cnt == 3'(NUM_DIG - 1));

`ifdef BCD_CHECK_EN
  logic erro_q;

  valida_bcd #(.DIG_W(DIG_W)) u_valida (
    .dig_in (dig_in),
    .ok     (digit_ok)
  );

  // A clear in the same cycle drops the digit silently, so no error is flagged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      erro_q <= 1'b0;
    else
      erro_q <= !limpar && dig_valid && dig_ready && !digit_ok;
  end

  assign erro = erro_q;
`else
  assign digit_ok = 1'b1;
  assign erro     = 1'b0;
`endif

  // Clear beats accept and consumir; consuming only rewinds the count, old digits linger.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= VAZIO;
      cnt      <= 3'd0;
      pronto_q <= 1'b0;
      for (int i = 0; i < NUM_DIG; i++) m[i] <= '0;
    end else if (limpar) begin
      state    <= VAZIO;
      cnt      <= 3'd0;
      pronto_q <= 1'b0;
      for (int i = 0; i < NUM_DIG; i++) m[i] <= '0;
    end else if (accept) begin
      for (int i = 0; i < NUM_DIG; i++)
        if (cnt == 3'(i)) m[i] <= dig_in;
      cnt <= cnt + 3'd1;
      if (last) begin
        state    <= CHEIO;
        pronto_q <= 1'b1;
      end else begin
        state <= CARREGA;
      end
    end else if (state == CHEIO && consumir) begin
      state    <= VAZIO;
      cnt      <= 3'd0;
      pronto_q <= 1'b0;
    end
  end

  assign pronto   = pronto_q;
  assign contagem = cnt;
  assign m0 = m[0];
  assign m1 = m[1];
  assign m2 = m[2];
  assign m3 = m[3];
  assign m4 = m[4];
  assign m5 = m[5];

endmodule

// File: tb/tb_registo_digitos.sv
// Self-checking bench for registo_digitos: a reference model pushes expected slot contents
// to a scoreboard queue as digits are offered; outputs are compared after each edge.
module tb_registo_digitos;

  localparam int DIG_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [DIG_W-1:0] dig_in;
  logic             dig_valid;
  logic             dig_ready;
  logic             limpar;
  logic             consumir;
  logic [DIG_W-1:0] m0, m1, m2, m3, m4, m5;
  logic             pronto;
  logic [2:0]       contagem;
  logic             erro;

  typedef struct {
    int               slot_idx;
    logic [DIG_W-1:0] val;
  } sb_t;

  sb_t              sb_q[$];
  logic [DIG_W-1:0] mdl_m [6];
  int               mdl_cnt;
  int               checks = 0;
  int               errors = 0;

  registo_digitos #(.DIG_W(DIG_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .dig_in    (dig_in),
    .dig_valid (dig_valid),
    .dig_ready (dig_ready),
    .limpar    (limpar),
    .consumir  (consumir),
    .m0        (m0),
    .m1        (m1),
    .m2        (m2),
    .m3        (m3),
    .m4        (m4),
    .m5        (m5),
    .pronto    (pronto),
    .contagem  (contagem),
    .erro      (erro)
  );

  always #5 clk = ~clk;

  function automatic logic [DIG_W-1:0] slot(input int i);
    case (i)
      0:       return m0;
      1:       return m1;
      2:       return m2;
      3:       return m3;
      4:       return m4;
      default: return m5;
    endcase
  endfunction

  function automatic bit bcd_ok(input logic [DIG_W-1:0] d);
`ifdef BCD_CHECK_EN
    return d <= 4'd9;
`else
    return 1'b1;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 6; i++) mdl_m[i] = '0;
    mdl_cnt = 0;
  endtask

  // One cycle of dig_valid; the model decides acceptance and the DUT status is checked after the edge.
  task automatic offer(input logic [DIG_W-1:0] d);
    bit in_room;
    bit exp_erro;
    in_room  = (mdl_cnt < 6);
    exp_erro = in_room && !bcd_ok(d);
    dig_valid = 1'b1;
    dig_in    = d;
    if (in_room && bcd_ok(d)) begin
      mdl_m[mdl_cnt] = d;
      sb_q.push_back('{slot_idx: mdl_cnt, val: d});
      mdl_cnt++;
    end
    step();
    dig_valid = 1'b0;
    checks++;
    if (contagem !== 3'(mdl_cnt)) begin
      errors++;
      $display("[TB] FAIL offer_contagem d=%0d: got %0d expected %0d", d, contagem, mdl_cnt);
    end
    checks++;
    if (pronto !== (mdl_cnt == 6)) begin
      errors++;
      $display("[TB] FAIL offer_pronto d=%0d: got %0b expected %0b", d, pronto, mdl_cnt == 6);
    end
    checks++;
    if (dig_ready !== (mdl_cnt < 6)) begin
      errors++;
      $display("[TB] FAIL offer_ready d=%0d: got %0b expected %0b", d, dig_ready, mdl_cnt < 6);
    end
    checks++;
    if (erro !== exp_erro) begin
      errors++;
      $display("[TB] FAIL offer_erro d=%0d: got %0b expected %0b", d, erro, exp_erro);
    end
  endtask

  task automatic drain_scoreboard(input string tag);
    sb_t it;
    while (sb_q.size() > 0) begin
      it = sb_q.pop_front();
      checks++;
      if (slot(it.slot_idx) !== it.val) begin
        errors++;
        $display("[TB] FAIL %s_m%0d: got %0d expected %0d", tag, it.slot_idx, slot(it.slot_idx), it.val);
      end
    end
  endtask

  task automatic compare_all_slots(input string tag);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (slot(i) !== mdl_m[i]) begin
        errors++;
        $display("[TB] FAIL %s_m%0d: got %0d expected %0d", tag, i, slot(i), mdl_m[i]);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; dig_valid = 1'b0; dig_in = '0; limpar = 1'b0; consumir = 1'b0;
    model_clear();
    #12;
    compare_all_slots("reset");
    checks++;
    if ({contagem, pronto, erro, dig_ready} !== {3'd0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("[TB] FAIL reset_status: got cnt=%0d pronto=%0b erro=%0b ready=%0b expected 0 0 0 1",
               contagem, pronto, erro, dig_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_fill();
    logic [DIG_W-1:0] digits [6];
    digits = '{4'd1, 4'd2, 4'd4, 4'd0, 4'd9, 4'd1};
    for (int i = 0; i < 6; i++) offer(digits[i]);
    drain_scoreboard("fill");
  endtask

  task automatic test_cheio_hold();
    for (int i = 0; i < 3; i++) offer(4'd7);
    compare_all_slots("hold");
    consumir = 1'b1;
    step();
    consumir = 1'b0;
    mdl_cnt = 0;
    checks++;
    if ({contagem, pronto, dig_ready} !== {3'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("[TB] FAIL consumir_status: got cnt=%0d pronto=%0b ready=%0b expected 0 0 1",
               contagem, pronto, dig_ready);
    end
    compare_all_slots("after_consumir");
  endtask

  task automatic test_limpar();
    offer(4'd5);
    offer(4'd6);
    consumir = 1'b1;
    step();
    consumir = 1'b0;
    checks++;
    if (contagem !== 3'd2) begin
      errors++;
      $display("[TB] FAIL consumir_outside_full: got %0d expected 2", contagem);
    end
    offer(4'd8);
    compare_all_slots("overwrite");
    drain_scoreboard("partial");
    limpar = 1'b1; dig_valid = 1'b1; dig_in = 4'd3;
    step();
    limpar = 1'b0; dig_valid = 1'b0;
    model_clear();
    compare_all_slots("limpar");
    checks++;
    if ({contagem, pronto, erro} !== {3'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL limpar_status: got cnt=%0d pronto=%0b erro=%0b expected 0 0 0",
               contagem, pronto, erro);
    end
  endtask

  task automatic test_bcd();
    offer(4'd3);
    offer(4'd10);
    offer(4'd5);
    compare_all_slots("bcd");
    drain_scoreboard("bcd");
  endtask

  task automatic test_async_reset();
    logic [DIG_W-1:0] more;
    offer(4'd2);
    offer(4'd7);
    offer(4'd1);
    drain_scoreboard("pre_reset");
    #3;
    rst_n = 1'b0;
    #1;
    model_clear();
    compare_all_slots("async_reset");
    checks++;
    if ({contagem, pronto, dig_ready} !== {3'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("[TB] FAIL async_reset_status: got cnt=%0d pronto=%0b ready=%0b expected 0 0 1",
               contagem, pronto, dig_ready);
    end
    #2;
    rst_n = 1'b1;
    step();
    offer(4'd6);
    checks++;
    if (m0 !== 4'd6) begin
      errors++;
      $display("[TB] FAIL post_reset_m0: got %0d expected 6", m0);
    end
    for (int i = 0; i < 5; i++) begin
      more = 4'($urandom_range(0, 9));
      offer(more);
    end
    drain_scoreboard("refill");
  endtask

  task automatic test_back_to_back();
    consumir = 1'b1;
    step();
    consumir = 1'b0;
    mdl_cnt = 0;
    offer(4'd4);
    offer(4'd8);
    compare_all_slots("back_to_back");
    drain_scoreboard("back_to_back");
  endtask

  initial begin
    test_reset();
    test_fill();
    test_cheio_hold();
    test_limpar();
    test_bcd();
    test_async_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
